// File: rtl/traffic_pkg.sv
// Shared traffic-controller types: road encoding, lamp codes, arbiter
// states and the round-robin road picker.
package traffic_pkg;

    typedef enum logic [1:0] {
        ROAD_M1 = 2'd0,
        ROAD_M2 = 2'd1,
        ROAD_MT = 2'd2,
        ROAD_S  = 2'd3
    } road_e;

    localparam int NUM_ROADS = 4;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } arb_state_e;

    // First requesting road at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] rr_select(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_ROADS; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/emergency_preempt_arbiter_if.sv
// Sensor inputs and grant/status outputs of the emergency preemption arbiter.
interface emergency_preempt_arbiter_if;
    logic [3:0] req_raw;
    logic       emergency_vehicle;
    logic [1:0] emergency_road;
    logic [3:0] req_filtered;
    logic       grant_timeout;

    modport master (
        output req_raw,
        input  emergency_vehicle, emergency_road, req_filtered, grant_timeout
    );

    modport slave (
        input  req_raw,
        output emergency_vehicle, emergency_road, req_filtered, grant_timeout
    );
endinterface

// File: rtl/emergency_preempt_arbiter_req_debounce.sv
// One sensor lane: 2-FF synchronizer followed by a mismatch-count debouncer.
module req_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Filtered level flips only after the synchronized level disagrees for DEBOUNCE_CYC cycles.
    always_comb begin
        s1_d   = raw;
        s2_d   = s1_q;
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                filt_d = s2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, filtered level and mismatch counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filtered = filt_q;
endmodule

// File: rtl/emergency_preempt_arbiter.sv
// Emergency-vehicle preemption: debounced requests, round-robin choice,
// bounded grant length and a fixed cooldown between grants.
module emergency_preempt_arbiter
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLD_MIN     = 8,
    parameter int HOLD_MAX     = 32,
    parameter int COOLDOWN     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    emergency_preempt_arbiter_if.slave   bus
);
    localparam int CNT_MAX = (HOLD_MAX > COOLDOWN) ? HOLD_MAX : COOLDOWN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [3:0]       req_filt;
    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_q, rr_d;
    road_e            road_q, road_d;
    logic             ev_q, ev_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       sel;
    logic             hold_min_done;
    logic             hold_max_hit;

    for (genvar g = 0; g < NUM_ROADS; g++) begin : g_deb
        req_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw      (bus.req_raw[g]),
            .filtered (req_filt[g])
        );
    end

    assign sel           = rr_select(req_filt, rr_q);
    assign hold_min_done = (cnt_q >= CNT_W'(HOLD_MIN - 1));
    assign hold_max_hit  = (cnt_q == CNT_W'(HOLD_MAX - 1));

    // Next state: the shared counter times the grant in GRANT and the cooldown in COOL.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        road_d    = road_q;
        ev_d      = ev_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_filt != 4'b0000) begin
                    state_d = ST_GRANT;
                    road_d  = road_e'(sel);
                    rr_d    = sel + 2'd1;
                    cnt_d   = '0;
                    ev_d    = 1'b1;
                end
            end
            ST_GRANT: begin
                if ((hold_min_done && !req_filt[road_q]) || hold_max_hit) begin
                    state_d   = ST_COOL;
                    cnt_d     = '0;
                    ev_d      = 1'b0;
                    timeout_d = hold_max_hit && req_filt[road_q];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COOL: begin
                if (cnt_q == CNT_W'(COOLDOWN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ev_d    = 1'b0;
            end
        endcase
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rr_q      <= 2'd0;
            road_q    <= ROAD_M1;
            ev_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            road_q    <= road_d;
            ev_q      <= ev_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.emergency_vehicle = ev_q;
    assign bus.emergency_road    = road_q;
    assign bus.req_filtered      = req_filt;
    assign bus.grant_timeout     = timeout_q;
endmodule

// File: doc/emergency_preempt_arbiter.md
EMERGENCY_PREEMPT_ARBITER -- requirements
Module: emergency_preempt_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive synchronized cycles a raw request must hold a new level before the filtered level changes.
REQ-002 Parameter HOLD_MIN, default 8: minimum grant length in cycles.
REQ-003 Parameter HOLD_MAX, default 32: maximum grant length in cycles; HOLD_MAX > HOLD_MIN >= 1.
REQ-004 Parameter COOLDOWN, default 4: cycles with no grant after each grant.
REQ-005 clk  in  1  single system clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_raw  in  4  asynchronous preemption sensors; bit0=M1, bit1=M2, bit2=MT, bit3=S.
REQ-008 emergency_vehicle  out  1  registered grant-active flag, consumed by TrafficLightController.
REQ-009 emergency_road  out  2  registered granted road: 00=M1, 01=M2, 10=MT, 11=S.
REQ-010 req_filtered  out  4  debounced request levels, for status.
REQ-011 grant_timeout  out  1  one-cycle pulse when a grant ends by HOLD_MAX.

Function
REQ-012 Each req_raw bit SHALL pass through a 2-FF synchronizer (s1, s2) before any other use.
REQ-013 Per bit, a mismatch counter SHALL increment each cycle s2 != filtered, clear when s2 == filtered, and filtered SHALL take s2 on the edge where the counter reaches DEBOUNCE_CYC (counter cleared).
REQ-014 A raw level held from sampling edge 0 SHALL change req_filtered at edge DEBOUNCE_CYC+1; shorter pulses SHALL never change it.
REQ-015 FSM states: IDLE, GRANT, COOL.
REQ-016 IDLE: if req_filtered != 0, next edge SHALL enter GRANT with emergency_vehicle=1 and emergency_road = selected road; else stay IDLE.
REQ-017 Selection SHALL be round-robin: lowest index at or after pointer rr (mod 4) with req_filtered set; on grant rr SHALL become granted index + 1 mod 4.
REQ-018 GRANT: hold counter starts at 0 on entry, increments each cycle; emergency_road SHALL be constant for the whole grant.
REQ-019 GRANT SHALL exit to COOL on the edge where (hold >= HOLD_MIN-1 and req_filtered[granted] == 0) or hold == HOLD_MAX-1, so a grant lasts HOLD_MIN..HOLD_MAX cycles.
REQ-020 HOLD_MAX exit with req_filtered[granted] still 1 SHALL pulse grant_timeout for exactly one cycle, aligned with the first COOL cycle.
REQ-021 Requests on other roads during GRANT SHALL NOT preempt or change emergency_road; they are served after COOL if still filtered-high.
REQ-022 COOL: emergency_vehicle=0 for exactly COOLDOWN cycles, then IDLE; IDLE lasts at least one cycle.
REQ-023 emergency_road SHALL hold the last granted value outside GRANT.
REQ-024 A granted road that re-requests after timeout SHALL be granted again only if no other road with round-robin precedence is requesting.

Reset
REQ-025 rst SHALL clear s1, s2, filtered, all counters; FSM=IDLE; rr=0.
REQ-026 Output reset values: emergency_vehicle=0, emergency_road=00, req_filtered=0000, grant_timeout=0.
REQ-027 rst asserted mid-GRANT or mid-COOL SHALL take effect on the next edge with no timeout pulse.

Structure
REQ-028 Road encoding enum (M1, M2, MT, S) and lamp constants SHALL live in shared package traffic_pkg, also used by TrafficLightController.
REQ-029 Synchronizer plus debounce SHALL be sub-module req_debounce, instantiated four times; FSM, arbiter and hold counter in the top.

Verification (defaults)
REQ-030 req_raw=0001 held from edge 0 -> req_filtered[0]=1 after edge 5, emergency_vehicle=1 and emergency_road=00 after edge 6.
REQ-031 req_raw[2] pulsed 3 cycles -> req_filtered and emergency_vehicle stay 0.
REQ-032 req_raw=1010 held simultaneously from reset -> grant road 01 first; after its 32-cycle grant, grant_timeout pulses and 4 COOL cycles plus 1 IDLE cycle follow, then grant road 11.
REQ-033 req_raw[0] asserted then dropped 2 cycles after grant -> emergency_vehicle high exactly 8 cycles, grant_timeout never pulses.
REQ-034 rst at hold=10 mid-grant -> next cycle all outputs at reset values, rr=0.
